debounced_gate_n: RTL and testbench

//  N-input switch-to-LED logic gate for the board exercises: successor to the fixed 2-input AND gate.

---
 rtl/debounced_gate_pkg.sv | 17 +
 rtl/debounced_gate_n_switch_debouncer.sv | 54 +++++
 rtl/debounced_gate_n.sv | 76 +++++++
 tb/tb_debounced_gate_n.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/debounced_gate_pkg.sv
// Shared types and helpers for the debounced N-input switch gate.
// The optional edge counter is enabled by defining EDGE_COUNT_EN.
package debounced_gate_pkg;

    typedef enum logic [1:0] {
        MODE_AND  = 2'b00,
        MODE_OR   = 2'b01,
        MODE_XOR  = 2'b10,
        MODE_NAND = 2'b11
    } gate_mode_t;

    // Debounce counter width: $clog2(cycles), never narrower than one bit.
    function automatic int deb_cnt_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/debounced_gate_n_switch_debouncer.sv
// One switch channel: two-flop synchroniser followed by a stable-count debouncer.
// The debounced level only follows the synchronised input after DEB_CYCLES agreeing samples.
module switch_debouncer
    import debounced_gate_pkg::*;
#(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw,
    output logic db
);

    localparam int            CW       = deb_cnt_width(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_reg;
    logic          s_reg;
    logic [CW-1:0] c_reg;
    logic [CW-1:0] c_next;
    logic          db_reg;
    logic          db_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            s_reg     <= 1'b0;
            c_reg     <= '0;
            db_reg    <= 1'b0;
        end else begin
            sync1_reg <= sw;
            s_reg     <= sync1_reg;
            c_reg     <= c_next;
            db_reg    <= db_next;
        end
    end

    // A sample that agrees with the accepted level restarts the count, so short pulses vanish.
    always_comb begin
        c_next  = c_reg;
        db_next = db_reg;
        if (s_reg == db_reg) begin
            c_next = '0;
        end else if (c_reg == CNT_LAST) begin
            db_next = s_reg;
            c_next  = '0;
        end else begin
            c_next = c_reg + CW'(1);
        end
    end

    assign db = db_reg;

endmodule

// File: rtl/debounced_gate_n.sv
// N debounced switches combined by a run-time selected AND/OR/XOR/NAND into a registered LED.
// Define EDGE_COUNT_EN to add the cnt port counting rising edges of the LED output.
module debounced_gate_n
    import debounced_gate_pkg::*;
#(
    parameter int N          = 3,
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     sw,
    input  logic [1:0]       mode,
`ifdef EDGE_COUNT_EN
    output logic [CNT_W-1:0] cnt,
`endif
    output logic             l
);

    if (N < 2 || DEB_CYCLES < 1 || CNT_W < 1) begin : g_bad_params
        $error("debounced_gate_n: N must be >= 2, DEB_CYCLES >= 1, CNT_W >= 1");
    end

    logic [N-1:0] db;
    logic         l_reg;
    logic         l_next;

    for (genvar gi = 0; gi < N; gi++) begin : g_chan
        switch_debouncer #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .sw    (sw[gi]),
            .db    (db[gi])
        );
    end

    // mode is already synchronous to clk, so it drives the mux directly.
    always_comb begin
        l_next = 1'b0;
        case (gate_mode_t'(mode))
            MODE_AND:  l_next = &db;
            MODE_OR:   l_next = |db;
            MODE_XOR:  l_next = ^db;
            MODE_NAND: l_next = ~&db;
            default:   l_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_reg <= 1'b0;
        end else begin
            l_reg <= l_next;
        end
    end

    assign l = l_reg;

`ifdef EDGE_COUNT_EN
    logic [CNT_W-1:0] cnt_reg;

    // Counts registered 0->1 transitions; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (!l_reg && l_next) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign cnt = cnt_reg;
`endif

endmodule

// File: tb/tb_debounced_gate_n.sv
// Directed bench for debounced_gate_n (N=3, DEB_CYCLES=4, CNT_W=8), edge counter checked when EDGE_COUNT_EN is defined.
`timescale 1ns/1ps
module tb_debounced_gate_n;

    logic       clk;
    logic       rst_n;
    logic [2:0] sw;
    logic [1:0] mode;
    logic       l;
`ifdef EDGE_COUNT_EN
    logic [7:0] cnt;
`endif

    int n_checks;
    int n_fail;

    debounced_gate_n #(
        .N          (3),
        .DEB_CYCLES (4),
        .CNT_W      (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (sw),
        .mode  (mode),
`ifdef EDGE_COUNT_EN
        .cnt   (cnt),
`endif
        .l     (l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1ns past the edge before sampling/driving.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Reset asserted with switches high: outputs cleared before any clock edge.
        rst_n = 1'b0;
        sw    = 3'b111;
        mode  = 2'b11;
        #2;
        chk("reset_l", {31'd0, l}, 32'd0);
`ifdef EDGE_COUNT_EN
        chk("reset_cnt", {24'd0, cnt}, 32'd0);
`endif
        tick(3);
        chk("reset_hold_l", {31'd0, l}, 32'd0);

        // Release with NAND selected: db is all zero so L rises on the first edge.
        rst_n = 1'b1;
        sw    = 3'b000;
        chk("pre_release_l", {31'd0, l}, 32'd0);
        tick(1);
        chk("nand_after_reset", {31'd0, l}, 32'd1);

        // AND, switches 000->111: L must be 0 at edge 6 and 1 at edge 7.
        mode = 2'b00;
        sw   = 3'b111;
        tick(6);
        chk("and_edge6", {31'd0, l}, 32'd0);
        tick(1);
        chk("and_edge7", {31'd0, l}, 32'd1);
        tick(5);
        chk("and_hold", {31'd0, l}, 32'd1);
`ifdef EDGE_COUNT_EN
        chk("cnt_after_and", {24'd0, cnt}, 32'd2);
`endif

        // Bounce rejection under OR.
        sw   = 3'b000;
        mode = 2'b01;
        tick(10);
        chk("bounce_settle", {31'd0, l}, 32'd0);
        sw = 3'b001;
        tick(3);
        sw = 3'b000;
        tick(12);
        chk("pulse3_ignored", {31'd0, l}, 32'd0);
        sw = 3'b001;
        tick(4);
        sw = 3'b000;
        tick(3);
        chk("pulse4_accepted", {31'd0, l}, 32'd1);
        tick(10);
        chk("pulse4_revert", {31'd0, l}, 32'd0);

        // Mode sweep with db=101.
        sw   = 3'b101;
        mode = 2'b00;
        tick(8);
        chk("sweep_and", {31'd0, l}, 32'd0);
        mode = 2'b01;
        tick(1);
        chk("sweep_or", {31'd0, l}, 32'd1);
        mode = 2'b10;
        tick(1);
        chk("sweep_xor", {31'd0, l}, 32'd0);
        mode = 2'b11;
        tick(1);
        chk("sweep_nand", {31'd0, l}, 32'd1);
`ifdef EDGE_COUNT_EN
        chk("cnt_after_sweep", {24'd0, cnt}, 32'd5);
`endif

        // Reset in the middle of a debounce: partial count is discarded.
        sw   = 3'b000;
        mode = 2'b00;
        tick(10);
        chk("midrst_settle", {31'd0, l}, 32'd0);
        sw = 3'b111;
        tick(2);
        #4;
        rst_n = 1'b0;
        #1;
        chk("midrst_async_l", {31'd0, l}, 32'd0);
`ifdef EDGE_COUNT_EN
        chk("midrst_async_cnt", {24'd0, cnt}, 32'd0);
`endif
        tick(2);
        rst_n = 1'b1;
        tick(6);
        chk("midrst_edge6", {31'd0, l}, 32'd0);
        tick(1);
        chk("midrst_edge7", {31'd0, l}, 32'd1);
`ifdef EDGE_COUNT_EN
        chk("midrst_cnt", {24'd0, cnt}, 32'd1);

        // 300 rising edges of L: counter wraps at 256 and ends at 44.
        rst_n = 1'b0;
        sw    = 3'b001;
        mode  = 2'b00;
        tick(1);
        rst_n = 1'b1;
        tick(8);
        chk("wrap_start_l", {31'd0, l}, 32'd0);
        chk("wrap_start_cnt", {24'd0, cnt}, 32'd0);
        for (int i = 0; i < 300; i++) begin
            mode = 2'b01;
            tick(1);
            mode = 2'b00;
            tick(1);
        end
        chk("wrap_end_l", {31'd0, l}, 32'd0);
        chk("wrap_cnt", {24'd0, cnt}, 32'd44);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
